// File: rtl/ecomp_pkg.sv
// Shared definitions for the compressed-extrinsic stream generator.
//   ecomp_size()            : width of the {min1, min2, pos, usign} word
//   pos_lsb/min2_lsb/min1_lsb : field offsets inside that word
//   POS_LSB/MIN2_LSB/MIN1_LSB : the same offsets for the default configuration
//   mag_tuple_t             : (m1, m2, pos) min-tree tuple at the default widths
package ecomp_pkg;

    localparam int unsigned DEF_WC     = 32;
    localparam int unsigned DEF_WABS   = 5;
    localparam int unsigned DEF_WCBITS = $clog2(DEF_WC);

    function automatic int unsigned ecomp_size(input int unsigned wc, input int unsigned wabs);
        return 2 * wabs + $clog2(wc) + wc;
    endfunction

    // Word layout, MSB to LSB: {min1, min2, pos, usign}
    function automatic int unsigned pos_lsb(input int unsigned wc);
        return wc;
    endfunction

    function automatic int unsigned min2_lsb(input int unsigned wc);
        return wc + $clog2(wc);
    endfunction

    function automatic int unsigned min1_lsb(input int unsigned wc, input int unsigned wabs);
        return min2_lsb(wc) + wabs;
    endfunction

    localparam int unsigned POS_LSB  = pos_lsb(DEF_WC);
    localparam int unsigned MIN2_LSB = min2_lsb(DEF_WC);
    localparam int unsigned MIN1_LSB = min1_lsb(DEF_WC, DEF_WABS);

    typedef struct packed {
        logic [DEF_WABS-1:0]   m1;
        logic [DEF_WABS-1:0]   m2;
        logic [DEF_WCBITS-1:0] pos;
    } mag_tuple_t;

endpackage

// File: rtl/ecomp_min_merge.sv
// Combinational merge of two (m1, m2, pos) tuples from a min tree.
//   a_i : tuple covering the lower lane indices (wins ties on m1)
//   b_i : tuple covering the higher lane indices
//   y_o : merged tuple; m1 = overall minimum, m2 = second smallest of the four values
// The tuple type is a parameter so the top can size fields for its own configuration.
module ecomp_min_merge
    import ecomp_pkg::*;
#(
    parameter type tuple_t = mag_tuple_t
) (
    input  tuple_t a_i,
    input  tuple_t b_i,
    output tuple_t y_o
);

    always_comb begin
        y_o = a_i;
        if (a_i.m1 <= b_i.m1) begin
            // Loser's m2 can never beat the winner's m2 or the loser's m1
            y_o.m1  = a_i.m1;
            y_o.pos = a_i.pos;
            y_o.m2  = (b_i.m1 < a_i.m2) ? b_i.m1 : a_i.m2;
        end else begin
            y_o.m1  = b_i.m1;
            y_o.pos = b_i.pos;
            y_o.m2  = (a_i.m1 < b_i.m2) ? a_i.m1 : b_i.m2;
        end
    end

endmodule

// File: rtl/ecomp_gen_stream.sv
// Stream-handshaked compressed-extrinsic generator for a min-sum check node.
// Each accepted beat (WC signs + WC magnitudes) yields {min1, min2, pos, usign}
// WCBITS+2 cycles later. One global enable stalls the whole pipeline.
//   clk, rst         : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready: input handshake; in_ready = !out_valid || out_ready
//   sign_in, mag_in  : per-edge signs and magnitudes (lane i at [i*WABS +: WABS])
//   out_valid/out_ready, ecomp : output handshake and result word
// Optional feature macro ECOMP_OFFSET_EN: subtract OFFSET (saturating at 0) from
// min1 and min2 in the output stage.
module ecomp_gen_stream
    import ecomp_pkg::*;
#(
    parameter int unsigned WC        = 32,
    parameter int unsigned WABS      = 5,
    parameter int unsigned WCBITS    = $clog2(WC),
    parameter int unsigned OFFSET    = 1,
    parameter int unsigned ECOMPSIZE = ecomp_size(WC, WABS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WC-1:0]        sign_in,
    input  logic [WC*WABS-1:0]   mag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ECOMPSIZE-1:0] ecomp
);

    localparam int unsigned P = 1 << WCBITS;

    typedef struct packed {
        logic [WABS-1:0]   m1;
        logic [WABS-1:0]   m2;
        logic [WCBITS-1:0] pos;
    } tuple_t;

    logic en;

    // vld_q[0]/sgn_q[0]/mag_q form stage 0; index k tracks tree level k
    logic [WCBITS:0]      vld_q;
    logic [WC-1:0]        sgn_q [WCBITS+1];
    logic [WC*WABS-1:0]   mag_q;

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves are P..2P-1
    tuple_t leaf   [P];
    tuple_t node_d [1:P-1];
    tuple_t node_q [1:P-1];

    logic [WABS-1:0]   min1_d, min1_q;
    logic [WABS-1:0]   min2_d, min2_q;
    logic [WCBITS-1:0] pos_q;
    logic [WC-1:0]     usign_d, usign_q;
    logic              out_valid_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < WC) begin : g_lane
            assign leaf[i] = '{m1: mag_q[i*WABS +: WABS], m2: {WABS{1'b1}}, pos: WCBITS'(i)};
        end else begin : g_pad
            // Pad lanes sit at higher indices, so ties never let them win
            assign leaf[i] = '{m1: {WABS{1'b1}}, m2: {WABS{1'b1}}, pos: WCBITS'(i)};
        end
    end

    for (genvar n = 1; n < P; n++) begin : g_node
        tuple_t a;
        tuple_t b;
        if (2 * n >= P) begin : g_from_leaf
            assign a = leaf[2*n - P];
            assign b = leaf[2*n + 1 - P];
        end else begin : g_from_node
            assign a = node_q[2*n];
            assign b = node_q[2*n + 1];
        end
        ecomp_min_merge #(
            .tuple_t(tuple_t)
        ) u_merge (
            .a_i(a),
            .b_i(b),
            .y_o(node_d[n])
        );
    end

`ifdef ECOMP_OFFSET_EN
    localparam logic [WABS-1:0] OFF = WABS'(OFFSET);
`endif

    always_comb begin
        usign_d = sgn_q[WCBITS] ^ {WC{^sgn_q[WCBITS]}};
`ifdef ECOMP_OFFSET_EN
        min1_d = (node_q[1].m1 > OFF) ? node_q[1].m1 - OFF : '0;
        min2_d = (node_q[1].m2 > OFF) ? node_q[1].m2 - OFF : '0;
`else
        min1_d = node_q[1].m1;
        min2_d = node_q[1].m2;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q       <= '0;
            mag_q       <= '0;
            for (int k = 0; k <= WCBITS; k++) begin
                sgn_q[k] <= '0;
            end
            for (int n = 1; n < P; n++) begin
                node_q[n] <= '0;
            end
            min1_q      <= '0;
            min2_q      <= '0;
            pos_q       <= '0;
            usign_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            vld_q    <= {vld_q[WCBITS-1:0], in_valid};
            mag_q    <= mag_in;
            sgn_q[0] <= sign_in;
            for (int k = 1; k <= WCBITS; k++) begin
                sgn_q[k] <= sgn_q[k-1];
            end
            for (int n = 1; n < P; n++) begin
                node_q[n] <= node_d[n];
            end
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            pos_q       <= node_q[1].pos;
            usign_q     <= usign_d;
            out_valid_q <= vld_q[WCBITS];
        end
    end

    assign out_valid = out_valid_q;
    assign ecomp     = {min1_q, min2_q, pos_q, usign_q};

endmodule

// File: doc/ecomp_gen_stream.md
# ecomp_gen_stream

Parametrised, stream-handshaked successor to the compressed-extrinsic generator in the min-sum check-node datapath. Each accepted beat carries one check node's WC sign bits and WC magnitudes. The block emits the compressed extrinsic word {min1, min2, pos, updated signs} after a fixed pipeline latency. It generalises check degree, including non-power-of-two values, adds valid/ready backpressure, and optionally applies offset min-sum correction. It sits between the variable-to-check message router and the check-node memory writer.

## Interface
- WC, 32, check-node degree, ≥2.
- WABS, 5, magnitude width (message width minus sign).
- WCBITS, $clog2(WC), position field width.
- OFFSET, 1, offset-min-sum β; used only with the macro.
- ECOMPSIZE, 2*WABS+WCBITS+WC, output word width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- sign_in  in  WC  per-edge sign bits.
- mag_in  in  WC*WABS  per-edge magnitudes; lane i at [i*WABS +: WABS].
- out_valid  out  1  ecomp holds a result.
- out_ready  in  1  downstream accepts.
- ecomp  out  ECOMPSIZE  {min1, min2, pos, usign}, MSB to LSB.

## Operation
- Global pipeline enable: en = !out_valid || out_ready. in_ready = en, combinational. A beat is accepted when in_valid && en.
- Stage 0 registers sign_in, mag_in, and the valid bit. Bubbles (in_valid=0) propagate with valid=0.
- Min tree:
  - Pad lanes up to P = 2^WCBITS. Pad lanes carry magnitude all-ones and index ≥ WC.
  - Each of the WCBITS levels merges pairs of (m1, m2, pos) tuples and is registered.
  - Merge rule: new m1 = min(a.m1, b.m1). On a tie, the lower-index side wins. New m2 = the smallest of the remaining three values.
  - At the leaves, m2 = all-ones.
- Sign path:
  - Signs are delayed alongside the tree.
  - parity = XOR of all WC signs. usign[i] = sign[i] ^ parity.
- Output stage registers min1, min2, pos, usign, and the valid bit.
- Ties: pos is the lowest index holding the minimum. If the minimum occurs twice, min2 = min1.
- Pad lanes are never selected as pos when WC < P, because real lanes have lower indices.
- Stall: when en=0, every stage, including stage 0, holds its contents. No beat is lost or duplicated, and order is preserved.
- Reset:
  - Clears all pipeline registers and valid bits. ecomp=0, out_valid=0 in the cycle after rst sampled low.
  - In-flight beats are discarded.
  - in_ready is 1 during reset because out_valid=0. Beats presented while rst is low are ignored.

## Timing
- Latency L = WCBITS + 2 cycles from acceptance to out_valid, with no stalls. WC=32 gives L=7; WC=6 gives L=5.
- Throughput is one beat per cycle while out_ready=1.
- Each stall cycle adds one cycle to every in-flight beat.
- Critical path is one WABS-bit three-way compare per tree level.

## Configuration
- ECOMP_OFFSET_EN defined: min1 and min2 each have OFFSET subtracted in the output stage, saturating at 0. pos and usign are unaffected. Latency is unchanged.
- Not defined: min1 and min2 are emitted raw. OFFSET is ignored.

## Structure
- Package ecomp_pkg holds:
  - the ECOMPSIZE computation function;
  - the field-slice constants for unpacking ecomp (MIN1_LSB, MIN2_LSB, POS_LSB);
  - the magnitude-tuple struct/typedef (m1, m2, pos).
- One sub-module, ecomp_min_merge: a combinational two-tuple merge, instantiated P-1 times across the tree by generate. Level registers and enables live in ecomp_gen_stream.

## Test plan
- WC=32, WABS=5, all lanes 17 except lane7=2 and lane20=4, sign_in=0x00000001, out_ready=1 -> 7 cycles later min1=2, min2=4, pos=7, usign=0xFFFFFFFE, out_valid=1 for one cycle.
- All lanes 9, sign_in=0 -> min1=9, min2=9, pos=0, usign=0.
- 10 back-to-back beats, out_ready low for cycles 8–10 -> in_ready=0 during the stall, ecomp held, all 10 results in order with no loss or duplication.
- rst low for one cycle while 4 beats are in flight -> out_valid=0 and ecomp=0 next cycle; no stale beat ever emerges.
- ECOMP_OFFSET_EN defined, OFFSET=1, mins 0 and 3 -> min1=0, min2=2. Without the macro -> 0 and 3.
- WC=6, lanes {5,5,1,7,1,3} -> latency 5, min1=1, min2=1, pos=2; padding never selected.
